// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write arbiter: widths, the
// hard-wired zero register and the holding-entry record type.
package rf_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    // Register 0 reads as zero; writes to it are discarded.
    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

    // One pending writeback entry. The destination field is called reg_addr
    // because "reg" is a reserved word.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] reg_addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_hold_slot.sv
// One-entry holding register for a writeback source, with its ready logic.
// A slot can take a new request whenever it is empty or its current entry
// is being granted this cycle.
module wb_hold_slot
    import rf_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_reg,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_grant,
    output logic              o_ready,
    output logic              o_accept,
    output wb_req_t           o_pend
);

    wb_req_t r_pend;
    logic    w_ready;
    logic    w_accept;

    assign w_ready  = !r_pend.valid || i_grant;
    assign w_accept = i_valid && w_ready;

    assign o_ready  = w_ready;
    assign o_accept = w_accept;
    assign o_pend   = r_pend;

    // Capture accepted requests (register 0 is accepted but never marked valid); drop the entry once granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else if (w_accept) begin
            r_pend.valid    <= (i_reg != ZERO_REG);
            r_pend.reg_addr <= i_reg;
            r_pend.data     <= i_data;
        end else if (i_grant) begin
            r_pend.valid <= 1'b0;
        end else begin
            r_pend <= r_pend;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port between the ALU (port 0) and
// load (port 1) writeback paths. Round-robin between different destinations,
// oldest-first for the same destination, registered write outputs and
// combinational read-hazard flags for decode.
module regfile_write_arbiter #(
    parameter int ADDR_W = rf_pkg::ADDR_W,
    parameter int DATA_W = rf_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb0_valid,
    input  logic [ADDR_W-1:0] wb0_reg,
    input  logic [DATA_W-1:0] wb0_data,
    output logic              wb0_ready,
    input  logic              wb1_valid,
    input  logic [ADDR_W-1:0] wb1_reg,
    input  logic [DATA_W-1:0] wb1_data,
    output logic              wb1_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wreg,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [ADDR_W-1:0] rd_reg1,
    input  logic [ADDR_W-1:0] rd_reg2,
    output logic              hazard1,
    output logic              hazard2
);

    import rf_pkg::*;

    wb_req_t           w_pend0;
    wb_req_t           w_pend1;
    logic              w_acc0;
    logic              w_acc1;
    logic              w_grant0;
    logic              w_grant1;
    logic              w_same;

    logic              r_rr_ptr;
    logic              r_older1;
    logic              r_we;
    logic [ADDR_W-1:0] r_wreg;
    logic [DATA_W-1:0] r_wdata;

    // True when rd names a register with a write still queued or in flight.
    function automatic logic rd_hazard(
        input logic [ADDR_W-1:0] rd,
        input wb_req_t           p0,
        input wb_req_t           p1,
        input logic              we,
        input logic [ADDR_W-1:0] wreg
    );
        return (rd != ZERO_REG) &&
               ((p0.valid && (p0.reg_addr == rd)) ||
                (p1.valid && (p1.reg_addr == rd)) ||
                (we && (wreg == rd)));
    endfunction

    wb_hold_slot u_slot0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (wb0_valid),
        .i_reg    (wb0_reg),
        .i_data   (wb0_data),
        .i_grant  (w_grant0),
        .o_ready  (wb0_ready),
        .o_accept (w_acc0),
        .o_pend   (w_pend0)
    );

    wb_hold_slot u_slot1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (wb1_valid),
        .i_reg    (wb1_reg),
        .i_data   (wb1_data),
        .i_grant  (w_grant1),
        .o_ready  (wb1_ready),
        .o_accept (w_acc1),
        .o_pend   (w_pend1)
    );

    // Pick the entry to write: the only one pending, else oldest on a shared destination, else round-robin
    always_comb begin
        w_same   = w_pend0.valid && w_pend1.valid &&
                   (w_pend0.reg_addr == w_pend1.reg_addr);
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (w_pend0.valid && w_pend1.valid) begin
            if (w_same) begin
                w_grant0 = !r_older1;
                w_grant1 = r_older1;
            end else begin
                w_grant0 = !r_rr_ptr;
                w_grant1 = r_rr_ptr;
            end
        end else begin
            w_grant0 = w_pend0.valid;
            w_grant1 = w_pend1.valid;
        end
    end

    // Rotate priority away from the last winner and remember which pending entry arrived first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= 1'b0;
            r_older1 <= 1'b0;
        end else begin
            if (w_grant0) begin
                r_rr_ptr <= 1'b1;
            end else if (w_grant1) begin
                r_rr_ptr <= 1'b0;
            end else begin
                r_rr_ptr <= r_rr_ptr;
            end

            if (w_acc0 && w_acc1) begin
                r_older1 <= 1'b0;
            end else if (w_acc0 && w_pend1.valid && !w_grant1) begin
                r_older1 <= 1'b1;
            end else if (w_acc1 && w_pend0.valid && !w_grant0) begin
                r_older1 <= 1'b0;
            end else begin
                r_older1 <= r_older1;
            end
        end
    end

    // Present the granted entry to the register file for exactly one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_wreg  <= '0;
            r_wdata <= '0;
        end else if (w_grant0) begin
            r_we    <= 1'b1;
            r_wreg  <= w_pend0.reg_addr;
            r_wdata <= w_pend0.data;
        end else if (w_grant1) begin
            r_we    <= 1'b1;
            r_wreg  <= w_pend1.reg_addr;
            r_wdata <= w_pend1.data;
        end else begin
            r_we    <= 1'b0;
            r_wreg  <= r_wreg;
            r_wdata <= r_wdata;
        end
    end

    assign rf_we    = r_we;
    assign rf_wreg  = r_wreg;
    assign rf_wdata = r_wdata;

    assign hazard1  = rd_hazard(rd_reg1, w_pend0, w_pend1, r_we, r_wreg);
    assign hazard2  = rd_hazard(rd_reg2, w_pend0, w_pend1, r_we, r_wreg);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios with
// literal expectations plus a randomized phase, all compared every cycle
// against an acceptance-order reference model.
module tb_regfile_write_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wb0_valid, wb1_valid;
    logic [AW-1:0] wb0_reg, wb1_reg;
    logic [DW-1:0] wb0_data, wb1_data;
    logic          wb0_ready, wb1_ready;
    logic          rf_we;
    logic [AW-1:0] rf_wreg;
    logic [DW-1:0] rf_wdata;
    logic [AW-1:0] rd_reg1, rd_reg2;
    logic          hazard1, hazard2;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb0_valid(wb0_valid), .wb0_reg(wb0_reg), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
        .wb1_valid(wb1_valid), .wb1_reg(wb1_reg), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
        .rf_we(rf_we), .rf_wreg(rf_wreg), .rf_wdata(rf_wdata),
        .rd_reg1(rd_reg1), .rd_reg2(rd_reg2),
        .hazard1(hazard1), .hazard2(hazard2)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: each pending entry carries its acceptance sequence number.
    bit            m_pv[2];
    logic [AW-1:0] m_preg[2];
    logic [DW-1:0] m_pdata[2];
    int            m_pseq[2];
    int            m_seq = 0;
    int            m_rr;
    bit            m_we;
    logic [AW-1:0] m_wreg;
    logic [DW-1:0] m_wdata;
    bit            e_gnt;
    int            e_win;
    bit            e_rdy[2];
    int            n_acc[2];
    int            n_writes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pv[0] = 1'b0; m_pv[1] = 1'b0;
        m_rr = 0; m_we = 1'b0; m_wreg = '0; m_wdata = '0;
    endtask

    function automatic bit exp_haz(input logic [AW-1:0] rd);
        if (rd == 5'd0) return 1'b0;
        return (m_pv[0] && m_preg[0] == rd) || (m_pv[1] && m_preg[1] == rd) ||
               (m_we && m_wreg == rd);
    endfunction

    task automatic model_eval();
        e_gnt = m_pv[0] || m_pv[1];
        if (m_pv[0] && m_pv[1]) begin
            if (m_preg[0] == m_preg[1]) e_win = (m_pseq[0] < m_pseq[1]) ? 0 : 1;
            else                        e_win = m_rr;
        end else begin
            e_win = m_pv[0] ? 0 : 1;
        end
        for (int p = 0; p < 2; p++) e_rdy[p] = !m_pv[p] || (e_gnt && e_win == p);
    endtask

    task automatic model_update();
        bit            acc[2];
        logic [AW-1:0] r[2];
        logic [DW-1:0] d[2];
        if (!rst_n) begin
            model_reset();
            return;
        end
        acc[0] = wb0_valid && e_rdy[0]; r[0] = wb0_reg; d[0] = wb0_data;
        acc[1] = wb1_valid && e_rdy[1]; r[1] = wb1_reg; d[1] = wb1_data;
        m_we = e_gnt;
        if (e_gnt) begin
            m_wreg  = m_preg[e_win];
            m_wdata = m_pdata[e_win];
            m_pv[e_win] = 1'b0;
            m_rr = (e_win == 0) ? 1 : 0;
        end
        for (int p = 0; p < 2; p++) begin
            if (acc[p]) begin
                n_acc[p]++;
                if (r[p] != 5'd0) begin
                    m_pv[p] = 1'b1; m_preg[p] = r[p]; m_pdata[p] = d[p];
                    m_pseq[p] = m_seq; m_seq++;
                end else begin
                    m_pv[p] = 1'b0;
                end
            end
        end
    endtask

    // Compare all outputs against the model, then advance one clock.
    task automatic cycle();
        #1;
        model_eval();
        chk("wb0_ready", wb0_ready, e_rdy[0]);
        chk("wb1_ready", wb1_ready, e_rdy[1]);
        chk("rf_we", rf_we, m_we);
        chk("rf_wreg", rf_wreg, m_wreg);
        chk("rf_wdata", rf_wdata, m_wdata);
        chk("hazard1", hazard1, exp_haz(rd_reg1));
        chk("hazard2", hazard2, exp_haz(rd_reg2));
        if (rf_we) n_writes++;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_in(input bit v0, input int r0, input int d0,
                          input bit v1, input int r1, input int d1);
        wb0_valid = v0; wb0_reg = AW'(r0); wb0_data = DW'(d0);
        wb1_valid = v1; wb1_reg = AW'(r1); wb1_data = DW'(d1);
    endtask

    task automatic idle(input int n);
        set_in(1'b0, 0, 0, 1'b0, 0, 0);
        for (int i = 0; i < n; i++) cycle();
    endtask

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] wlog[$];
    int            prev_port;
    int            port;
    int            a0, a1;
    int            p0_idx;

    initial begin
        n_acc[0] = 0; n_acc[1] = 0;
        rst_n = 1'b0; rd_reg1 = '0; rd_reg2 = '0;
        set_in(1'b0, 0, 0, 1'b0, 0, 0);
        model_reset();
        cycle(); cycle();
        chk("reset_we", rf_we, 1'b0);
        chk("reset_rdy0", wb0_ready, 1'b1);
        chk("reset_rdy1", wb1_ready, 1'b1);
        rst_n = 1'b1;
        idle(2);

        // Single write: reg 8, data 90
        rd_reg1 = 5'd8;
        set_in(1'b1, 8, 90, 1'b0, 0, 0);
        cycle();
        chk("single_haz_E", hazard1, 1'b1);
        chk("single_we_E", rf_we, 1'b0);
        set_in(1'b0, 0, 0, 1'b0, 0, 0);
        cycle();
        chk("single_we", rf_we, 1'b1);
        chk("single_wreg", rf_wreg, 5'd8);
        chk("single_wdata", rf_wdata, 32'd90);
        chk("single_haz_E1", hazard1, 1'b1);
        cycle();
        chk("single_we_off", rf_we, 1'b0);
        chk("single_haz_off", hazard1, 1'b0);
        idle(2);

        // Reset mid-stream with both entries pending
        rd_reg1 = 5'd5; rd_reg2 = 5'd6;
        set_in(1'b1, 5, 32'h55, 1'b1, 6, 32'h66);
        cycle();
        set_in(1'b1, 10, 32'h1010, 1'b1, 11, 32'h1111);
        cycle();
        chk("prerst_we", rf_we, 1'b1);
        chk("prerst_haz1", hazard1, 1'b1);
        chk("prerst_haz2", hazard2, 1'b1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_we", rf_we, 1'b0);
        chk("rst_rdy0", wb0_ready, 1'b1);
        chk("rst_rdy1", wb1_ready, 1'b1);
        chk("rst_haz1", hazard1, 1'b0);
        chk("rst_haz2", hazard2, 1'b0);
        set_in(1'b0, 0, 0, 1'b0, 0, 0);
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("postrst_we", rf_we, 1'b0);
        end

        // Simultaneous writes to different registers
        set_in(1'b1, 3, 7, 1'b1, 4, 9);
        cycle();
        set_in(1'b0, 0, 0, 1'b0, 0, 0);
        cycle();
        chk("sim_first_reg", rf_wreg, 5'd3);
        chk("sim_first_data", rf_wdata, 32'd7);
        cycle();
        chk("sim_second_we", rf_we, 1'b1);
        chk("sim_second_reg", rf_wreg, 5'd4);
        chk("sim_second_data", rf_wdata, 32'd9);
        cycle();
        chk("sim_done_we", rf_we, 1'b0);
        idle(2);

        // Continuous streaming on both ports: grants must alternate 0,1,0,1
        prev_port = 1;
        a0 = 0; a1 = 0;
        for (int i = 0; i < 14; i++) begin
            set_in(1'b1, 16 + (a0 % 8), 32'h100 + a0, 1'b1, 1 + (a1 % 8), 32'h200 + a1);
            cycle();
            if (wb0_valid && e_rdy[0]) a0++;
            if (wb1_valid && e_rdy[1]) a1++;
            if (rf_we) begin
                port = (rf_wreg >= 5'd16) ? 0 : 1;
                chk("alternate", port, 1 - prev_port);
                prev_port = port;
            end
        end
        idle(4);

        // Same register: port 1 first, then port 0
        set_in(1'b0, 0, 0, 1'b1, 8, 45);
        cycle();
        set_in(1'b1, 8, 90, 1'b0, 0, 0);
        cycle();
        chk("order_first", rf_wdata, 32'd45);
        set_in(1'b0, 0, 0, 1'b0, 0, 0);
        cycle();
        chk("order_second_we", rf_we, 1'b1);
        chk("order_second", rf_wdata, 32'd90);

        // Same register, accepted together while the pointer favours port 1
        set_in(1'b1, 2, 11, 1'b0, 0, 0);
        cycle();
        set_in(1'b1, 8, 90, 1'b1, 8, 45);
        cycle();
        chk("age_pre", rf_wdata, 32'd11);
        set_in(1'b0, 0, 0, 1'b0, 0, 0);
        cycle();
        chk("age_first", rf_wdata, 32'd90);
        cycle();
        chk("age_second", rf_wdata, 32'd45);
        idle(2);

        // Register 0 discard
        rd_reg2 = 5'd0;
        set_in(1'b0, 0, 0, 1'b1, 0, 32'hFFFF_FFFF);
        cycle();
        chk("r0_ready", wb1_ready, 1'b1);
        chk("r0_haz2", hazard2, 1'b0);
        set_in(1'b0, 0, 0, 1'b0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("r0_no_we", rf_we, 1'b0);
        end

        // Streaming backpressure: 4 requests on port 0, 1 on port 1
        for (int i = 0; i < 4; i++) q0.push_back(32'(1000 + i));
        q1.push_back(32'd2000);
        n_writes = 0;
        for (int i = 0; i < 40; i++) begin
            set_in(q0.size() > 0, 20 + (q0.size() > 0 ? int'(q0[0]) - 1000 : 0),
                   q0.size() > 0 ? int'(q0[0]) : 0,
                   q1.size() > 0, 12, q1.size() > 0 ? int'(q1[0]) : 0);
            cycle();
            if (wb0_valid && e_rdy[0]) void'(q0.pop_front());
            if (wb1_valid && e_rdy[1]) void'(q1.pop_front());
            if (rf_we) wlog.push_back(rf_wdata);
        end
        chk("stream_drained", q0.size() + q1.size(), 0);
        chk("stream_writes", n_writes, 5);
        p0_idx = 0;
        a1 = 0;
        foreach (wlog[i]) begin
            if (wlog[i] == 32'd2000) a1++;
            else begin
                chk("stream_p0_order", wlog[i], 32'(1000 + p0_idx));
                p0_idx++;
            end
        end
        chk("stream_p1_once", a1, 1);

        // Randomized traffic with a reset in the middle
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom,
                   $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom);
            rd_reg1 = AW'($urandom_range(0, 7));
            rd_reg2 = AW'($urandom_range(0, 7));
            if (i == 200) begin
                rst_n = 1'b0;
                model_reset();
                cycle();
                rst_n = 1'b1;
            end else begin
                cycle();
            end
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
